// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front-end: access sizes and FSM states.
// No logic beyond a misalignment helper; no latency.
// No flow control here.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned to that size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Byte-lane extract/extend and lane merge for sub-word memory accesses.
// Purely combinational, zero latency.
// No flow control; used by the owning FSM during its access cycle.
module mem_lane_ext
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] new_data,
  output logic [31:0] ext_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  assign shamt   = {offset, 3'b000};
  assign shifted = rd_word >> shamt;

  // Select the addressed lane, extend it, and build the store merge.
  always_comb begin
    ext_data  = rd_word;
    lane_mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        ext_data  = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF;
      end
      SZ_HALF: begin
        ext_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        ext_data  = rd_word;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merged_word = (rd_word & ~(lane_mask << shamt)) | ((new_data & lane_mask) << shamt);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front-end onto a word-addressed memory (sub-word stores via RMW).
// Latency from accept: error 1, load/word store 2, sub-word store 3 cycles to done.
// req_ready only in IDLE; one request in flight, no queuing.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [31:0]       dm_rdata
);

  state_t      state, state_nxt;
  logic        wr_q, sgn_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q;
  logic [31:0] wbuf;
  logic [31:0] ext_data, merged_word;
  logic        accept, req_err;

  // Upper address bits only select aliases of the same word.
  wire unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept   = req_valid && (state == ST_IDLE);
  assign req_err  = is_misaligned(req_size, req_addr[1:0]);
  assign dm_wdata = wbuf;

  mem_lane_ext u_lane (
    .rd_word     (dm_rdata),
    .offset      (off_q),
    .size        (size_q),
    .sign_ext    (sgn_q),
    .new_data    (wdata_q),
    .ext_data    (ext_data),
    .merged_word (merged_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: errors skip memory; only sub-word stores need the WRITE beat.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = (wr_q && size_q != SZ_WORD) ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_nxt = ST_RESP;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; memory strobes exist only in ACCESS/WRITE.
  always_comb begin
    req_ready = (state == ST_IDLE);
    done      = (state == ST_RESP);
    misalign  = (state == ST_RESP) && err_q;
    dm_we     = 1'b0;
    dm_re     = 1'b0;
    case (state)
      ST_ACCESS: begin
        if (wr_q && size_q == SZ_WORD) dm_we = 1'b1;
        else                           dm_re = 1'b1;
      end
      ST_WRITE: dm_we = 1'b1;
      default: ;
    endcase
  end

  // Request latch, load result and write buffer (which also drives dm_wdata).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      sgn_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      off_q     <= 2'b00;
      wdata_q   <= '0;
      wbuf      <= '0;
      load_data <= '0;
      dm_addr   <= '0;
    end else if (accept) begin
      wr_q      <= req_write;
      sgn_q     <= req_signed;
      err_q     <= req_err;
      size_q    <= req_size;
      off_q     <= req_addr[1:0];
      wdata_q   <= req_wdata;
      dm_addr   <= req_addr[ADDR_W+1:2];
      load_data <= '0;
      if (req_write && req_size == SZ_WORD && !req_err) wbuf <= req_wdata;
    end else if (state == ST_ACCESS) begin
      if (!wr_q)                 load_data <= ext_data;
      else if (size_q != SZ_WORD) wbuf     <= merged_word;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        done, misalign, dm_we, dm_re;
  logic [31:0] load_data, dm_wdata, dm_rdata;
  logic [3:0]  dm_addr;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .load_data(load_data), .misalign(misalign),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
    .dm_rdata(dm_rdata)
  );

  // Data memory model
  logic [31:0] mem [16];
  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_wdata;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    logic [3:0]  addr;
    int          lat;
    int          we_cnt;
    int          we_off;
    int          re_cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0, errors = 0;
  int   cyc = 0, acc_cyc = 0, done_cyc = 0, we_cnt = 0, re_cnt = 0, we_off = 0;
  bit   busy = 0, gap_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, scores each completed request
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      busy = 0;
    end else begin
      if (!busy && (dm_we || dm_re)) check("stray_mem_access", 1, 0);
      if (busy) begin
        if (dm_we) begin we_cnt++; we_off = cyc - acc_cyc; end
        if (dm_re) re_cnt++;
      end
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e_mon = sb.pop_front();
          check("load_data", load_data, e_mon.ld);
          check("misalign", {31'b0, misalign}, {31'b0, e_mon.err});
          check("dm_addr", {28'b0, dm_addr}, {28'b0, e_mon.addr});
          check("latency", cyc - acc_cyc, e_mon.lat);
          check("we_cycles", we_cnt, e_mon.we_cnt);
          check("we_offset", we_off, e_mon.we_off);
          check("re_cycles", re_cnt, e_mon.re_cnt);
        end
        busy = 0;
        done_cyc = cyc;
      end
      if (req_valid && req_ready) begin
        if (gap_chk) begin
          check("b2b_gap", cyc - done_cyc, 1);
          gap_chk = 0;
        end
        busy = 1; acc_cyc = cyc; we_cnt = 0; re_cnt = 0; we_off = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("drain_timeout", 0, 1);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_ld, input bit exp_err,
                       input bit push, input bit hold);
    exp_t e;
    int n;
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr;
    req_wdata = wd; req_valid = 1'b1;
    e.ld = exp_ld; e.err = exp_err; e.addr = addr[5:2];
    if (exp_err)           begin e.lat = 1; e.we_cnt = 0; e.we_off = 0; e.re_cnt = 0; end
    else if (!wr)          begin e.lat = 2; e.we_cnt = 0; e.we_off = 0; e.re_cnt = 1; end
    else if (sz == SZ_WORD) begin e.lat = 2; e.we_cnt = 1; e.we_off = 1; e.re_cnt = 0; end
    else                   begin e.lat = 3; e.we_cnt = 1; e.we_off = 2; e.re_cnt = 1; end
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ready_timeout", 0, 1);
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    if (!hold) begin
      req_valid = 1'b0;
      if (push) wait_idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_done", {31'b0, done}, 0);
    check("rst_misalign", {31'b0, misalign}, 0);
    check("rst_load_data", load_data, 0);
    check("rst_dm_we_re", {30'b0, dm_we, dm_re}, 0);
    check("rst_dm_addr", {28'b0, dm_addr}, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then load
    issue(1, SZ_WORD, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, 1, 0);
    check("mem2_sw", mem[2], 32'hDEADBEEF);
    issue(0, SZ_WORD, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, 1, 0);

    // Byte store read-modify-write
    issue(1, SZ_BYTE, 0, 32'h09, 32'h12345678, 32'h0, 0, 1, 0);
    check("mem2_sb", mem[2], 32'hDEAD78EF);

    // Load extension
    issue(0, SZ_BYTE, 1, 32'h09, 32'h0, 32'h00000078, 0, 1, 0);
    issue(0, SZ_BYTE, 1, 32'h0B, 32'h0, 32'hFFFFFFDE, 0, 1, 0);
    issue(0, SZ_BYTE, 0, 32'h0B, 32'h0, 32'h000000DE, 0, 1, 0);
    issue(0, SZ_HALF, 1, 32'h0A, 32'h0, 32'hFFFFDEAD, 0, 1, 0);
    issue(0, SZ_HALF, 0, 32'h0A, 32'h0, 32'h0000DEAD, 0, 1, 0);
    issue(0, SZ_HALF, 1, 32'h08, 32'h0, 32'h000078EF, 0, 1, 0);
    issue(0, SZ_BYTE, 1, 32'h08, 32'h0, 32'hFFFFFFEF, 0, 1, 0);

    // Halfword store into upper lane of word 3
    issue(1, SZ_HALF, 0, 32'h0E, 32'h0000CAFE, 32'h0, 0, 1, 0);
    check("mem3_sh", mem[3], 32'hCAFE0000);

    // Errors
    issue(0, SZ_WORD, 0, 32'h06, 32'h0, 32'h0, 1, 1, 0);
    issue(1, SZ_HALF, 0, 32'h03, 32'hFFFFFFFF, 32'h0, 1, 1, 0);
    issue(0, SZ_RSVD, 1, 32'h00, 32'h0, 32'h0, 1, 1, 0);
    issue(1, SZ_RSVD, 0, 32'h08, 32'h55555555, 32'h0, 1, 1, 0);
    check("mem0_err", mem[0], 32'h0);
    check("mem2_err", mem[2], 32'hDEAD78EF);

    // Reset mid-store
    issue(1, SZ_WORD, 0, 32'h00, 32'h11223344, 32'h0, 0, 1, 0);
    check("mem0_init", mem[0], 32'h11223344);
    issue(1, SZ_HALF, 0, 32'h00, 32'h0000BEEF, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    check("rmw_write_we", {31'b0, dm_we}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dm_we", {31'b0, dm_we}, 0);
    check("arst_done", {31'b0, done}, 0);
    check("arst_req_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mem0_after_rst", mem[0], 32'h11223344);
    check("ready_after_rst", {31'b0, req_ready}, 1);

    // Back-to-back with address wrap
    issue(1, SZ_WORD, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0, 1, 1);
    gap_chk = 1;
    issue(0, SZ_WORD, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 0, 1, 0);
    check("mem0_wrap", mem[0], 32'hA5A5A5A5);
    check("gap_checked", {31'b0, gap_chk}, 0);

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end between the datapath and the word-addressed data memory. Accepts byte/halfword/word load and store requests on byte addresses and translates them into whole-word accesses on the data-memory port. Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended data. Requests that are misaligned or use a reserved size are rejected without touching memory.

## Interface
- `ADDR_W`, default 4: word-address width of the data-memory port (16 words).
- `clk` input 1: clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request; request accepted when `req_valid && req_ready`.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `req_signed` input 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `done` output 1: one-cycle pulse marking request completion.
- `load_data` output 32: extended load result; valid while `done` is high.
- `misalign` output 1: valid with `done`; 1 = request rejected.
- `dm_addr` output ADDR_W: word address = latched `req_addr[ADDR_W+1:2]`.
- `dm_wdata` output 32: full word written to the data memory.
- `dm_we` output 1: data-memory write enable; memory writes on the rising edge where this is high.
- `dm_re` output 1: data-memory read enable.
- `dm_rdata` input 32: data-memory read word, combinational from `dm_addr`.

## Operation
- Byte lanes are little-endian: offset 0 is [7:0] and offset 3 is [31:24]. A halfword at offset 0 is [15:0]; at offset 2 it is [31:16].
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4·2^ADDR_W bytes.
- FSM states are IDLE, ACCESS, WRITE and RESP.
- **IDLE**
  - `req_ready`=1.
  - On accept, latch all request fields.
  - Error case: half with addr[0]=1, word with addr[1:0]≠0, or size 11. Go to RESP with the error flag set.
  - Otherwise go to ACCESS.
- **ACCESS**
  - Load: `dm_re`=1. Extract the lane from `dm_rdata`, extend it, and register the result into `load_data`. Go to RESP.
  - Word store: `dm_we`=1 with `dm_wdata`=latched wdata. Go to RESP.
  - Sub-word store: `dm_re`=1. Merge the new lane into `dm_rdata` and register the merged word into the write buffer. Go to WRITE.
- **WRITE**: `dm_we`=1 with `dm_wdata`=write buffer. Go to RESP.
- **RESP**
  - `done`=1. `misalign` shows the error flag.
  - `load_data` = extended result for loads; 0 for stores and errors.
  - Go to IDLE.
- Outside ACCESS and WRITE: `dm_we`=`dm_re`=0. `dm_wdata` and `dm_addr` hold their last values.
- An error request never asserts `dm_we` or `dm_re`.

## Timing
- Latency from the accept edge (cycle T):
  - Load or word store: `done` in T+2.
  - Sub-word store: `done` in T+3.
  - Error: `done` in T+1.
- Throughput: one request per latency+1 cycles. `req_ready` is high only in IDLE.
- `req_*` inputs are ignored outside the accept cycle. Holding `req_valid` high issues back-to-back requests.
- Memory update for stores:
  - Word store: at the edge ending ACCESS.
  - Sub-word store: at the edge ending WRITE.
  - The memory contents are visible to a following request.
- Reset values: state IDLE, `req_ready`=1, `done`=0, `misalign`=0, `load_data`=0, `dm_we`=0, `dm_re`=0, `dm_addr`=0, `dm_wdata`=0, write buffer 0.
- Reset mid-operation: all outputs take their reset values immediately (asynchronously). An in-flight request is dropped with no `done`.
  - A sub-word store reset during ACCESS or WRITE leaves memory unchanged.
  - A word store reset during ACCESS leaves memory unchanged, because `dm_we` drops before the edge.

## Structure
- Package `mem_pkg`: size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, plus the FSM state enum.
- Sub-module `mem_lane_ext`: purely combinational.
  - Extract path: (word, offset, size, signed) → extended result.
  - Merge path: (old word, new data, offset, size) → merged word.
  - Used in ACCESS.

## Test plan
- **Word store then load**
  - sw 0xDEADBEEF to 0x08: `dm_we` in T+1, `dm_addr`=2, `done` in T+2.
  - Then lw 0x08: `load_data`=0xDEADBEEF, `misalign`=0.
- **Byte store read-modify-write**
  - With word 2 = 0xDEADBEEF, sb 0x12345678 to 0x09.
  - `dm_we` only in T+2; word 2 becomes 0xDEAD78EF; `done` in T+3.
- **Load extension** (with word 2 = 0xDEAD78EF)
  - lb 0x09 signed → 0x00000078.
  - lb 0x0B signed → 0xFFFFFFDE; lbu 0x0B → 0x000000DE.
  - lh 0x0A signed → 0xFFFFDEAD; lhu → 0x0000DEAD.
- **Errors**
  - lw 0x06, sh 0x03, and size 11 at 0x00.
  - Each gives `done` in T+1 with `misalign`=1 and `load_data`=0.
  - `dm_we`/`dm_re` never high; memory unchanged.
- **Reset mid-store**: sh 0xBEEF to 0x00 over 0x11223344, with `rst_n` dropped during WRITE.
  - `dm_we` falls immediately; word 0 stays 0x11223344.
  - No `done`; `req_ready`=1 after release.
- **Back-to-back and wrap**: `req_valid` held high with sw 0xA5A5A5A5 to 0x40, then lw 0x00.
  - Second accepted only in the cycle after `done`.
  - Returns 0xA5A5A5A5 (address wraps to word 0).
